alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for ALU32. Buffers operand/opcode commands in a small FIFO and drives
//  ALU32's a/b/func from registers. Captures alu_out once ALU32's registered latency has elapsed.

---
 rtl/alu_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus a one-at-a-time issue/capture sequencer in front of the registered ALU32.
// Each result is returned with its caller tag over a valid/ready port, in FIFO order.
module alu_cmd_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [3:0]               cmd_func,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_func,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, OUT} state_t;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [3:0]       mem_func [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_func_q, alu_func_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_err_q, res_err_d;
    logic             push;
    logic             issue;

    assign cmd_ready = (count_q != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;

    // Contents need no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_a[wr_ptr_q]    <= cmd_a;
            mem_b[wr_ptr_q]    <= cmd_b;
            mem_func[wr_ptr_q] <= cmd_func;
            mem_tag[wr_ptr_q]  <= cmd_tag;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_func_d  = alu_func_q;
        tag_d       = tag_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        issue       = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    issue   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                res_data_d  = alu_result;
                res_tag_d   = tag_q;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != '0) begin
                        issue   = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            alu_a_d    = mem_a[rd_ptr_q];
            alu_b_d    = mem_b[rd_ptr_q];
            alu_func_d = mem_func[rd_ptr_q];
            tag_d      = mem_tag[rd_ptr_q];
            err_d      = (mem_func[rd_ptr_q] == FUNC_DIV) && (mem_b[rd_ptr_q] == '0);
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        // Push and pop together leave the occupancy unchanged.
        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_func_q  <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_func_q  <= alu_func_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_func   = alu_func_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;
    assign res_err    = res_err_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-stage registered ALU32 stand-in.
// Each scenario task drives its own stimulus and checks hand-computed results inline.
module tb_alu_cmd_sequencer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_a;
    logic [WIDTH-1:0]  cmd_b;
    logic [3:0]        cmd_func;
    logic [TAG_W-1:0]  cmd_tag;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [3:0]        alu_func;
    logic [WIDTH-1:0]  alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;
    logic [2:0]        fifo_count;
    logic              busy;

    int tests_run;
    int tests_failed;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_err(res_err),
        .fifo_count(fifo_count), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU32 stand-in: operands sampled at one edge, result visible after it.
    function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic [3:0] f);
        case (f)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return (b == '0) ? 32'hFFFF_FFFF : a / b;
            4'b0111: return a & b;
            4'b1111: return {31'd0, a == b};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_model(alu_a, alu_b, alu_func);

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [3:0] f, input logic [TAG_W-1:0] t);
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_func  = f;
        cmd_tag   = t;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (accepted !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL push_accept tag %0d: got %0b expected 1", t, accepted);
        end
    endtask

    task automatic wait_result(output bit seen, output int waited);
        waited = 0;
        while (!res_valid && waited < 20) begin
            step();
            waited++;
        end
        seen = res_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if ({res_valid, busy, fifo_count, cmd_ready, res_err} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000010",
                     {res_valid, busy, fifo_count, cmd_ready, res_err});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_func, res_data, res_tag} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got a=%0h b=%0h f=%0h d=%0h t=%0h expected all 0",
                     alu_a, alu_b, alu_func, res_data, res_tag);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit seen;
        int waited;
        res_ready = 1'b1;
        push_cmd(32'd5, 32'd3, 4'b0000, 4'd1);
        tests_run++;
        if (fifo_count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_count: got %0d expected 1", fifo_count);
        end
        wait_result(seen, waited);
        tests_run++;
        if (!seen || waited != 3) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got seen=%0b after %0d edges expected 1 after 3", seen, waited);
        end
        tests_run++;
        if ({res_data, res_tag, res_err} !== {32'd8, 4'd1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL single_result: got d=%0h t=%0d e=%0b expected d=8 t=1 e=0", res_data, res_tag, res_err);
        end
        step();
        tests_run++;
        if ({res_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got valid=%0b busy=%0b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_fifo_order();
        logic [WIDTH-1:0] exp_data [5];
        bit seen;
        int waited;
        exp_data = '{32'd2, 32'd5, 32'h30, 32'd1, 32'd4};
        res_ready = 1'b0;
        push_cmd(32'd1,   32'd1,   4'b0000, 4'd1);
        push_cmd(32'd9,   32'd4,   4'b0001, 4'd2);
        push_cmd(32'hF0,  32'h3C,  4'b0111, 4'd3);
        push_cmd(32'd7,   32'd7,   4'b1111, 4'd4);
        push_cmd(32'd2,   32'd2,   4'b0000, 4'd5);
        tests_run++;
        if ({fifo_count, cmd_ready, res_valid} !== {3'd4, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL order_full: got count=%0d ready=%0b valid=%0b expected 4 0 1",
                     fifo_count, cmd_ready, res_valid);
        end
        cmd_valid = 1'b1;
        cmd_a     = 32'd99;
        cmd_b     = 32'd99;
        cmd_func  = 4'b0000;
        cmd_tag   = 4'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({cmd_ready, fifo_count} !== {1'b0, 3'd4}) begin
                tests_failed++;
                $display("[TB] FAIL order_blocked cycle %0d: got ready=%0b count=%0d expected 0 4",
                         i, cmd_ready, fifo_count);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_result(seen, waited);
            tests_run++;
            if (!seen || {res_data, res_tag, res_err} !== {exp_data[i], 4'(i + 1), 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL order_result %0d: got seen=%0b d=%0h t=%0d e=%0b expected d=%0h t=%0d e=0",
                         i, seen, res_data, res_tag, res_err, exp_data[i], i + 1);
            end
            if (i > 0) begin
                tests_run++;
                if (waited != 2) begin
                    tests_failed++;
                    $display("[TB] FAIL order_throughput %0d: got %0d edges expected 2", i, waited);
                end
            end
            step();
        end
        tests_run++;
        if ({busy, fifo_count} !== {1'b0, 3'd0}) begin
            tests_failed++;
            $display("[TB] FAIL order_drained: got busy=%0b count=%0d expected 0 0", busy, fifo_count);
        end
    endtask

    task automatic test_stall();
        bit seen;
        int waited;
        res_ready = 1'b0;
        push_cmd(32'd20,  32'd22, 4'b0000, 4'd7);
        push_cmd(32'd100, 32'd1,  4'b0001, 4'd8);
        wait_result(seen, waited);
        tests_run++;
        if (!seen || {res_data, res_tag} !== {32'd42, 4'd7}) begin
            tests_failed++;
            $display("[TB] FAIL stall_first: got seen=%0b d=%0h t=%0d expected d=2a t=7", seen, res_data, res_tag);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if ({res_valid, res_data, res_tag, fifo_count, alu_a} !== {1'b1, 32'd42, 4'd7, 3'd1, 32'd20}) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold cycle %0d: got v=%0b d=%0h t=%0d c=%0d a=%0h expected 1 2a 7 1 14",
                         i, res_valid, res_data, res_tag, fifo_count, alu_a);
            end
        end
        res_ready = 1'b1;
        step();
        tests_run++;
        if ({res_valid, alu_a, fifo_count, busy} !== {1'b0, 32'd100, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got v=%0b a=%0h c=%0d busy=%0b expected 0 64 0 1",
                     res_valid, alu_a, fifo_count, busy);
        end
        wait_result(seen, waited);
        tests_run++;
        if (!seen || {res_data, res_tag} !== {32'd99, 4'd8}) begin
            tests_failed++;
            $display("[TB] FAIL stall_second: got seen=%0b d=%0h t=%0d expected d=63 t=8", seen, res_data, res_tag);
        end
        step();
    endtask

    task automatic test_div_zero();
        bit seen;
        int waited;
        res_ready = 1'b1;
        push_cmd(32'd10, 32'd0, 4'b0011, 4'd9);
        wait_result(seen, waited);
        tests_run++;
        if (!seen || {res_tag, res_err} !== {4'd9, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL div_zero_err: got seen=%0b t=%0d e=%0b expected t=9 e=1", seen, res_tag, res_err);
        end
        step();
        push_cmd(32'd10, 32'd2, 4'b0011, 4'd10);
        wait_result(seen, waited);
        tests_run++;
        if (!seen || {res_data, res_tag, res_err} !== {32'd5, 4'd10, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL div_ok: got seen=%0b d=%0h t=%0d e=%0b expected d=5 t=10 e=0",
                     seen, res_data, res_tag, res_err);
        end
        step();
    endtask

    task automatic test_full_pop();
        logic [WIDTH-1:0] exp_data [5];
        logic [TAG_W-1:0] exp_tag [5];
        bit seen;
        int waited;
        exp_data = '{32'd104, 32'd106, 32'd108, 32'd110, 32'd207};
        exp_tag  = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_cmd(32'(100 + i), 32'(i), 4'b0000, 4'(10 + i));
        end
        tests_run++;
        if ({fifo_count, res_valid, res_data, res_tag} !== {3'd4, 1'b1, 32'd102, 4'd11}) begin
            tests_failed++;
            $display("[TB] FAIL full_first: got c=%0d v=%0b d=%0h t=%0d expected 4 1 66 11",
                     fifo_count, res_valid, res_data, res_tag);
        end
        cmd_valid = 1'b1;
        cmd_a     = 32'd200;
        cmd_b     = 32'd7;
        cmd_func  = 4'b0000;
        cmd_tag   = 4'd0;
        res_ready = 1'b1;
        step();
        tests_run++;
        if ({fifo_count, cmd_ready, res_valid} !== {3'd3, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL full_pop_edge: got c=%0d ready=%0b v=%0b expected 3 1 0",
                     fifo_count, cmd_ready, res_valid);
        end
        step();
        cmd_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL full_push_next: got %0d expected 4", fifo_count);
        end
        for (int i = 0; i < 5; i++) begin
            wait_result(seen, waited);
            tests_run++;
            if (!seen || {res_data, res_tag} !== {exp_data[i], exp_tag[i]}) begin
                tests_failed++;
                $display("[TB] FAIL full_wrap %0d: got seen=%0b d=%0h t=%0d expected d=%0h t=%0d",
                         i, seen, res_data, res_tag, exp_data[i], exp_tag[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_exec();
        bit quiet;
        res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_cmd(32'(i), 32'(i), 4'b0000, 4'(i));
        end
        res_ready = 1'b1;
        step();
        tests_run++;
        if ({busy, fifo_count, res_valid} !== {1'b1, 3'd2, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL rst_exec_setup: got busy=%0b c=%0d v=%0b expected 1 2 0", busy, fifo_count, res_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if ({fifo_count, res_valid, busy, cmd_ready, alu_a} !== {3'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL rst_exec_clear: got c=%0d v=%0b busy=%0b ready=%0b a=%0h expected 0 0 0 1 0",
                     fifo_count, res_valid, busy, cmd_ready, alu_a);
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (res_valid || busy) quiet = 1'b0;
        end
        tests_run++;
        if (quiet !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_exec_dropped: got activity=1 expected 0");
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_func     = '0;
        cmd_tag      = '0;
        res_ready    = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fifo_order();
        test_stall();
        test_div_zero();
        test_full_pop();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
